router_packet_tx: RTL and testbench
===================================

// Module: router_packet_tx
// PURPOSE
//  Transmit end of the 13-bit router packet interface. Accepts payload/dest/type requests
//  from upstream over valid/ready, queues them, and drives one packet at a time to the router
//  with a valid/ack handshake. It checks for timeouts and retries, then drops the packet.
//  Sits between the traffic source and the router controller/datapath.
// PARAMETERS
//  DEPTH      4   request queue entries (power of 2, >=2)
//  TIMEOUT    8   cycles pkt_valid may stay high without pkt_ack before one retry (>=2)
//  MAX_RETRY  2   retries before the packet is dropped (0 = drop on first timeout)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-low
//  in_valid     in   1   upstream request valid
//  in_ready     out  1   queue can accept (= !full)
//  in_dest      in   2   destination register address
//  in_type      in   2   packet type; 2'b11 is illegal
//  in_payload   in   8   payload byte
//  packet       out  13  {parity, payload[7:0], type[1:0], dest[1:0]}
//  pkt_valid    out  1   packet on bus is valid
//  pkt_ack      in   1   router has consumed packet (sampled only while pkt_valid=1)
//  err_type     out  1   1-cycle pulse: request with type 2'b11 discarded
//  err_timeout  out  1   1-cycle pulse: packet dropped after MAX_RETRY retries
//  sent_count   out  8   packets acknowledged, wraps 255->0
// BEHAVIOUR
//  - Reset (rst=0): queue empty, state IDLE, packet=0, pkt_valid=0, in_ready=1 after release,
//    err_type=0, err_timeout=0, sent_count=0. Reset mid-transfer aborts it; the queue is lost.
//  - Packet bit 12 = even parity: ^packet[11:0], so the 13-bit word has an even number of 1s.
//  - Accept on posedge when in_valid & in_ready. in_ready = !full, even if a pop occurs
//    in the same cycle. in_valid=1 with a full queue leaves no effect until space frees.
//  - Accepted request with in_type==2'b11: not enqueued; err_type=1 the next cycle.
//  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH. Full when count==DEPTH, empty when count==0.
//  - FSM states: IDLE, SEND, GAP.
//    IDLE: if !empty -> SEND; at that edge, load packet from the queue head and set pkt_valid=1.
//          Accept at edge N into an empty queue -> pkt_valid=1 after edge N+1.
//    SEND: pkt_valid=1; packet held stable. tmo_cnt counts SEND cycles from 0.
//          pkt_ack=1 -> pop head, sent_count++, retry_cnt=0.
//            If the queue still holds another entry, go to SEND and load the next head
//            (back-to-back, no idle cycle). Otherwise go to IDLE with pkt_valid=0.
//          No ack and tmo_cnt==TIMEOUT-1:
//            retry_cnt<MAX_RETRY -> retry_cnt++, go to GAP (pkt_valid=0 for one cycle).
//            retry_cnt==MAX_RETRY -> pop, err_timeout=1 for one cycle, retry_cnt=0, go to IDLE.
//          pkt_ack on the same cycle as the timeout: the ack wins and the packet counts as sent.
//    GAP: pkt_valid=0, packet unchanged; go to SEND next cycle, tmo_cnt=0.
//  - pkt_ack while pkt_valid=0 is ignored.
//  - When pkt_valid=0, packet holds its last value; the router must not sample it.
// TESTING
//  1 Reset: rst=0 mid-SEND -> pkt_valid=0, packet=0, in_ready=1, sent_count=0 immediately.
//  2 Single send: dest=2, type=1, payload=8'hA5 -> packet=13'h0A56 (parity 0).
//    pkt_valid rises 1 cycle after accept; ack -> sent_count=1, pkt_valid falls.
//  3 Illegal type: type=2'b11 -> err_type pulses once, no pkt_valid, queue stays empty.
//  4 Fill/back-to-back: push 4 with no ack -> in_ready=0. A 5th push is held until an ack.
//    Ack every cycle -> 4 packets in FIFO order, with pkt_valid continuously high.
//  5 Timeout: with TIMEOUT=8, MAX_RETRY=2 and no ack -> 3 windows of 8 cycles of valid,
//    separated by 1-cycle gaps. err_timeout pulses once, then the packet is dropped.
//  6 Ack exactly at cycle TIMEOUT-1 of the first window -> counted as sent, no retry,
//    err_timeout=0.

Source files
------------

// File: rtl/router_packet_tx.sv
// router_packet_tx
// This is the transmit end of the 13-bit router packet interface. Upstream requests
// ({payload, type, dest}) are accepted over valid/ready into a small circular queue.
// Packets are then driven to the router one at a time with a valid/ack handshake.
// A packet that is not acknowledged within TIMEOUT cycles is retried after a one-cycle
// gap. After MAX_RETRY retries it is dropped and err_timeout pulses.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   in_valid        upstream request valid
//   in_ready        queue can accept (not full)
//   in_dest         destination register address
//   in_type         packet type (2'b11 is illegal and is discarded)
//   in_payload      payload byte
//   packet          {parity, payload, type, dest}; parity makes the word even
//   pkt_valid       packet on the bus is valid
//   pkt_ack         router consumed the packet
//   err_type        one-cycle pulse when an illegal-type request is discarded
//   err_timeout     one-cycle pulse when a packet is dropped after all retries
//   sent_count      number of acknowledged packets, wraps at 255
module router_packet_tx #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_dest,
  input  logic [1:0]  in_type,
  input  logic [7:0]  in_payload,
  output logic [12:0] packet,
  output logic        pkt_valid,
  input  logic        pkt_ack,
  output logic        err_type,
  output logic        err_timeout,
  output logic [7:0]  sent_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t         state, state_next;
  logic [11:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           full, empty, accept, push, pop;
  logic [11:0]    head, next_head;

  logic [12:0]    packet_next;
  logic           valid_next;
  logic [TW-1:0]  tmo_cnt, tmo_next;
  logic [RW-1:0]  retry_cnt, retry_next;
  logic           err_timeout_next;
  logic           sent_inc;

  function automatic logic [12:0] encode(input logic [11:0] d);
    return {^d, d};
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign accept    = in_valid & in_ready;
  assign push      = accept & (in_type != 2'b11);
  assign head      = mem[rd_ptr];
  // The head is still in the queue while it is being sent, so the next
  // packet for a back-to-back load sits one slot past the read pointer.
  assign next_head = mem[rd_ptr + AW'(1)];

  // Queue storage. It has no reset because occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_payload, in_type, in_dest};
  end

  // Queue pointers and occupancy. Both pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // An accepted request with the illegal type is swallowed and flagged one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_type <= 1'b0;
    else      err_type <= accept & (in_type == 2'b11);
  end

  // State and transmit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      packet      <= '0;
      pkt_valid   <= 1'b0;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
      err_timeout <= 1'b0;
      sent_count  <= '0;
    end else begin
      state       <= state_next;
      packet      <= packet_next;
      pkt_valid   <= valid_next;
      tmo_cnt     <= tmo_next;
      retry_cnt   <= retry_next;
      err_timeout <= err_timeout_next;
      if (sent_inc) sent_count <= sent_count + 8'd1;
    end
  end

  // Next-state logic. In SEND, an ack takes priority over a timeout in the same cycle.
  // When the head has just been popped and another entry remains, that entry is loaded
  // straight away so pkt_valid stays high with no idle cycle.
  always_comb begin
    state_next       = state;
    packet_next      = packet;
    valid_next       = pkt_valid;
    tmo_next         = tmo_cnt;
    retry_next       = retry_cnt;
    err_timeout_next = 1'b0;
    sent_inc         = 1'b0;
    pop              = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next  = SEND;
          packet_next = encode(head);
          valid_next  = 1'b1;
          tmo_next    = '0;
        end
      end
      SEND: begin
        if (pkt_ack) begin
          pop        = 1'b1;
          sent_inc   = 1'b1;
          retry_next = '0;
          if (count > CW'(1)) begin
            packet_next = encode(next_head);
            tmo_next    = '0;
          end else begin
            state_next = IDLE;
            valid_next = 1'b0;
          end
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          valid_next = 1'b0;
          if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_next = retry_cnt + RW'(1);
            state_next = GAP;
          end else begin
            pop              = 1'b1;
            err_timeout_next = 1'b1;
            retry_next       = '0;
            state_next       = IDLE;
          end
        end else begin
          tmo_next = tmo_cnt + TW'(1);
        end
      end
      GAP: begin
        state_next = SEND;
        valid_next = 1'b1;
        tmo_next   = '0;
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_router_packet_tx.sv
// tb_router_packet_tx
// This is a directed testbench for router_packet_tx with its default parameters
// (DEPTH=4, TIMEOUT=8, MAX_RETRY=2). Inputs change and outputs are sampled on the
// falling edge of the clock. Expected packet words are worked out by hand as
// {even parity, payload, type, dest}.
module tb_router_packet_tx;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_dest;
  logic [1:0]  in_type;
  logic [7:0]  in_payload;
  logic [12:0] packet;
  logic        pkt_valid;
  logic        pkt_ack;
  logic        err_type;
  logic        err_timeout;
  logic [7:0]  sent_count;

  int checks = 0;
  int errors = 0;

  router_packet_tx dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dest     (in_dest),
    .in_type     (in_type),
    .in_payload  (in_payload),
    .packet      (packet),
    .pkt_valid   (pkt_valid),
    .pkt_ack     (pkt_ack),
    .err_type    (err_type),
    .err_timeout (err_timeout),
    .sent_count  (sent_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] d, input logic [1:0] t,
                               input logic [7:0] p, input logic a);
    in_valid   = v;
    in_dest    = d;
    in_type    = t;
    in_payload = p;
    pkt_ack    = a;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_valid",   16'(pkt_valid),   16'h0);
    checkOutput("rst_packet",  16'(packet),      16'h0);
    checkOutput("rst_ready",   16'(in_ready),    16'h1);
    checkOutput("rst_sent",    16'(sent_count),  16'h0);
    checkOutput("rst_errtype", 16'(err_type),    16'h0);
    checkOutput("rst_errtmo",  16'(err_timeout), 16'h0);
    rst = 1'b1;
    tick();

    // Single send: dest=2 type=1 payload=A5 gives 0x0A56 with parity 0.
    $display("[TB] single send");
    applyStimulus(1'b1, 2'd2, 2'd1, 8'hA5, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    checkOutput("single_valid_lat", 16'(pkt_valid), 16'h0);
    tick();
    checkOutput("single_valid", 16'(pkt_valid), 16'h1);
    checkOutput("single_packet", 16'(packet), 16'h0A56);
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    checkOutput("single_valid_fall", 16'(pkt_valid), 16'h0);
    checkOutput("single_sent", 16'(sent_count), 16'h1);
    checkOutput("single_packet_hold", 16'(packet), 16'h0A56);

    // Illegal type: discarded, err_type pulses for exactly one cycle.
    $display("[TB] illegal type");
    applyStimulus(1'b1, 2'd1, 2'd3, 8'h3C, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    checkOutput("illegal_err", 16'(err_type), 16'h1);
    checkOutput("illegal_valid0", 16'(pkt_valid), 16'h0);
    tick();
    checkOutput("illegal_err_fall", 16'(err_type), 16'h0);
    checkOutput("illegal_valid1", 16'(pkt_valid), 16'h0);
    tick();
    checkOutput("illegal_valid2", 16'(pkt_valid), 16'h0);

    // Fill and back-to-back sends.
    $display("[TB] fill and back-to-back");
    applyStimulus(1'b1, 2'd0, 2'd0, 8'h11, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, 2'd1, 8'h22, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd2, 2'd2, 8'h33, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd3, 2'd0, 8'h45, 1'b0);
    tick();
    checkOutput("fill_ready", 16'(in_ready), 16'h0);
    checkOutput("fill_valid", 16'(pkt_valid), 16'h1);
    checkOutput("fill_pkt0", 16'(packet), 16'h0110);
    applyStimulus(1'b1, 2'd1, 2'd2, 8'h57, 1'b0);
    tick();
    checkOutput("full_hold_ready", 16'(in_ready), 16'h0);
    checkOutput("full_hold_pkt0", 16'(packet), 16'h0110);
    applyStimulus(1'b1, 2'd1, 2'd2, 8'h57, 1'b1);
    tick();
    checkOutput("b2b_pkt1", 16'(packet), 16'h0225);
    checkOutput("b2b_valid1", 16'(pkt_valid), 16'h1);
    checkOutput("b2b_ready1", 16'(in_ready), 16'h1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1);
    checkOutput("b2b_pkt2", 16'(packet), 16'h033A);
    checkOutput("b2b_valid2", 16'(pkt_valid), 16'h1);
    tick();
    checkOutput("b2b_pkt3", 16'(packet), 16'h1453);
    checkOutput("b2b_valid3", 16'(pkt_valid), 16'h1);
    tick();
    checkOutput("b2b_pkt4", 16'(packet), 16'h1579);
    checkOutput("b2b_valid4", 16'(pkt_valid), 16'h1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    checkOutput("b2b_valid_fall", 16'(pkt_valid), 16'h0);
    checkOutput("b2b_sent", 16'(sent_count), 16'd6);

    // Timeout: three 8-cycle windows separated by 1-cycle gaps, then drop.
    $display("[TB] timeout and retry");
    applyStimulus(1'b1, 2'd0, 2'd1, 8'h0F, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    tick();
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("tmo_w%0d_c%0d_valid", w, i), 16'(pkt_valid), 16'h1);
        checkOutput($sformatf("tmo_w%0d_c%0d_pkt", w, i), 16'(packet), 16'h10F4);
        checkOutput($sformatf("tmo_w%0d_c%0d_err", w, i), 16'(err_timeout), 16'h0);
        tick();
      end
      checkOutput($sformatf("tmo_w%0d_gap_valid", w), 16'(pkt_valid), 16'h0);
      if (w < 2) begin
        checkOutput($sformatf("tmo_w%0d_gap_err", w), 16'(err_timeout), 16'h0);
        checkOutput($sformatf("tmo_w%0d_gap_pkt", w), 16'(packet), 16'h10F4);
        tick();
      end else begin
        checkOutput("tmo_drop_err", 16'(err_timeout), 16'h1);
        tick();
        checkOutput("tmo_err_fall", 16'(err_timeout), 16'h0);
        checkOutput("tmo_idle_valid", 16'(pkt_valid), 16'h0);
        checkOutput("tmo_sent", 16'(sent_count), 16'd6);
        checkOutput("tmo_ready", 16'(in_ready), 16'h1);
      end
    end

    // Ack on the last cycle of the first window still counts as sent.
    $display("[TB] ack at timeout boundary");
    applyStimulus(1'b1, 2'd3, 2'd2, 8'h80, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    tick();
    checkOutput("edge_pkt", 16'(packet), 16'h080B);
    repeat (7) tick();
    checkOutput("edge_valid_last", 16'(pkt_valid), 16'h1);
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    checkOutput("edge_valid_fall", 16'(pkt_valid), 16'h0);
    checkOutput("edge_sent", 16'(sent_count), 16'd7);
    checkOutput("edge_err", 16'(err_timeout), 16'h0);
    tick();
    checkOutput("edge_no_retry", 16'(pkt_valid), 16'h0);
    checkOutput("edge_err2", 16'(err_timeout), 16'h0);

    // An ack while idle is ignored.
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    checkOutput("stray_ack_sent", 16'(sent_count), 16'd7);

    // Reset in the middle of a send, with a second entry queued.
    $display("[TB] reset mid-send");
    applyStimulus(1'b1, 2'd1, 2'd0, 8'hFF, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd2, 2'd1, 8'h12, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    checkOutput("mid_valid", 16'(pkt_valid), 16'h1);
    checkOutput("mid_pkt", 16'(packet), 16'h1FF1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 16'(pkt_valid), 16'h0);
    checkOutput("mid_rst_packet", 16'(packet), 16'h0);
    checkOutput("mid_rst_ready", 16'(in_ready), 16'h1);
    checkOutput("mid_rst_sent", 16'(sent_count), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_valid1", 16'(pkt_valid), 16'h0);
    tick();
    checkOutput("post_rst_valid2", 16'(pkt_valid), 16'h0);
    checkOutput("post_rst_ready", 16'(in_ready), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
